// File: rtl/rotary_key_pkg.sv
// Shared types and constants for the rotary encoder / push-key decoder.
package rotary_key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_PRESSED,
        KEY_LONG
    } key_state_t;

    localparam int unsigned FLAG_STEP  = 0;
    localparam int unsigned FLAG_PRESS = 1;
    localparam int unsigned FLAG_LONG  = 2;
    localparam int unsigned FLAG_ERR   = 3;

    // Position of an {A,B} pair along the CW quadrature cycle 00->01->11->10.
    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   quad_phase = 2'd0;
            2'b01:   quad_phase = 2'd1;
            2'b11:   quad_phase = 2'd2;
            default: quad_phase = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/rk_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
module rk_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000,
    parameter logic        RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level
);

    logic        sync_1;
    logic        sync_2;
    logic [15:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= RESET_VAL;
            sync_2     <= RESET_VAL;
            level      <= RESET_VAL;
            stable_cnt <= '0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
            // The level flips on the DEBOUNCE_CYC-th consecutive differing sample.
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == 16'(DEBOUNCE_CYC - 1)) begin
                level      <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/rotary_key_decoder.sv
// Quadrature encoder position counter plus push-key FSM with sticky event flags.
module rotary_key_decoder
    import rotary_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 1000,
    parameter int unsigned LONG_PRESS_CYC = 50000000,
    parameter int unsigned POS_W          = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    key_n,
    input  logic                    pos_clr,
    input  logic [3:0]              flag_clr,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    key_level,
    output logic [3:0]              flags,
    output logic                    evt_pulse
);

    logic        a_lvl;
    logic        b_lvl;
    logic        key_n_lvl;
    logic [1:0]  ab_now;
    logic [1:0]  ab_q;
    logic [1:0]  phase_delta;
    logic        step_cw;
    logic        step_ccw;
    logic        step_bad;
    logic        press_evt;
    logic        long_evt;
    logic [3:0]  flag_set;
    logic [31:0] hold_cnt;
    key_state_t  key_state;

    rk_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b0)) u_deb_a (
        .clk(ACLK), .rst(ARESET), .pin(enc_a), .level(a_lvl)
    );

    rk_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b0)) u_deb_b (
        .clk(ACLK), .rst(ARESET), .pin(enc_b), .level(b_lvl)
    );

    rk_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b1)) u_deb_key (
        .clk(ACLK), .rst(ARESET), .pin(key_n), .level(key_n_lvl)
    );

    always_comb begin
        ab_now      = {a_lvl, b_lvl};
        // Phase distance 1 = CW, 3 = CCW, 2 = both phases moved at once.
        phase_delta = quad_phase(ab_now) - quad_phase(ab_q);
        step_cw     = (phase_delta == 2'd1);
        step_ccw    = (phase_delta == 2'd3);
        step_bad    = (phase_delta == 2'd2);
        press_evt   = (key_state == KEY_IDLE) && !key_n_lvl;
        long_evt    = (key_state == KEY_PRESSED) && !key_n_lvl
                      && (hold_cnt == 32'(LONG_PRESS_CYC - 1));
        flag_set             = '0;
        flag_set[FLAG_STEP]  = step_cw | step_ccw;
        flag_set[FLAG_PRESS] = press_evt;
        flag_set[FLAG_LONG]  = long_evt;
        flag_set[FLAG_ERR]   = step_bad;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ab_q     <= '0;
            position <= '0;
            dir      <= 1'b0;
        end else begin
            ab_q <= ab_now;
            if (pos_clr) begin
                position <= '0;
            end else if (step_cw) begin
                position <= position + POS_W'(1);
                dir      <= 1'b1;
            end else if (step_ccw) begin
                position <= position - POS_W'(1);
                dir      <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            key_state <= KEY_IDLE;
            hold_cnt  <= '0;
            key_level <= 1'b0;
        end else begin
            case (key_state)
                KEY_IDLE: begin
                    if (press_evt) begin
                        key_state <= KEY_PRESSED;
                        hold_cnt  <= '0;
                        key_level <= 1'b1;
                    end
                end
                KEY_PRESSED: begin
                    if (key_n_lvl) begin
                        key_state <= KEY_IDLE;
                        key_level <= 1'b0;
                    end else if (long_evt) begin
                        key_state <= KEY_LONG;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                KEY_LONG: begin
                    if (key_n_lvl) begin
                        key_state <= KEY_IDLE;
                        key_level <= 1'b0;
                    end
                end
                default: begin
                    key_state <= KEY_IDLE;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            flags     <= '0;
            evt_pulse <= 1'b0;
        end else begin
            flags     <= (flags & ~flag_clr) | flag_set;
            evt_pulse <= |flag_set;
        end
    end

endmodule

// File: tb/tb_rotary_key_decoder.sv
// Directed bench for rotary_key_decoder with a per-cycle behavioural reference.
module tb_rotary_key_decoder;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned PW   = 8;

    logic                 ACLK     = 1'b0;
    logic                 ARESET   = 1'b1;
    logic                 enc_a    = 1'b0;
    logic                 enc_b    = 1'b0;
    logic                 key_n    = 1'b1;
    logic                 pos_clr  = 1'b0;
    logic [3:0]           flag_clr = '0;
    logic signed [PW-1:0] position;
    logic                 dir;
    logic                 key_level;
    logic [3:0]           flags;
    logic                 evt_pulse;

    rotary_key_decoder #(
        .DEBOUNCE_CYC(DEB),
        .LONG_PRESS_CYC(LONG),
        .POS_W(PW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enc_a(enc_a), .enc_b(enc_b), .key_n(key_n),
        .pos_clr(pos_clr), .flag_clr(flag_clr), .position(position), .dir(dir),
        .key_level(key_level), .flags(flags), .evt_pulse(evt_pulse)
    );

    always #5 ACLK = ~ACLK;

    int n_checks  = 0;
    int n_fail    = 0;
    int evt_seen  = 0;
    int evt_base  = 0;

    // Reference state: raw pin history per channel (bit 0 newest), debounced levels.
    logic signed [PW-1:0] m_pos    = '0;
    logic                 m_dir    = 1'b0;
    logic                 m_key    = 1'b0;
    logic [3:0]           m_flags  = '0;
    logic                 m_evt    = 1'b0;
    logic [1:0]           m_ab_old = '0;
    int                   m_held   = 0;
    logic [15:0]          m_hist[3];
    logic                 m_lvl[3];
    int                   ring_of[4] = '{0, 1, 3, 2};
    logic [1:0]           cw_seq[4]  = '{2'b01, 2'b11, 2'b10, 2'b00};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = '0; m_dir = 1'b0; m_key = 1'b0; m_flags = '0; m_evt = 1'b0;
        m_ab_old = '0; m_held = 0;
        m_hist[0] = '0; m_hist[1] = '0; m_hist[2] = '1;
        m_lvl[0] = 1'b0; m_lvl[1] = 1'b0; m_lvl[2] = 1'b1;
    endtask

    // Advances the reference by one rising edge, using the inputs seen at that edge.
    task automatic model_step();
        logic [3:0] set;
        logic [1:0] cur;
        logic       pin[3];
        logic       v;
        logic       all_v;
        int         d;
        if (ARESET) begin
            model_reset();
        end else begin
            set = '0;
            cur = {m_lvl[0], m_lvl[1]};
            d = (ring_of[cur] - ring_of[m_ab_old] + 4) % 4;
            if (d == 2) set[3] = 1'b1;
            if (d == 1 || d == 3) set[0] = 1'b1;
            if (pos_clr) m_pos = '0;
            else if (d == 1) begin m_pos = m_pos + 8'sd1; m_dir = 1'b1; end
            else if (d == 3) begin m_pos = m_pos - 8'sd1; m_dir = 1'b0; end
            m_ab_old = cur;
            if (!m_lvl[2]) begin
                if (m_held < 1000) m_held++;
                if (m_held == 1) set[1] = 1'b1;
                if (m_held == LONG + 1) set[2] = 1'b1;
            end else begin
                m_held = 0;
            end
            m_key   = (m_held > 0);
            m_flags = (m_flags & ~flag_clr) | set;
            m_evt   = |set;
            pin[0] = enc_a; pin[1] = enc_b; pin[2] = key_n;
            for (int ch = 0; ch < 3; ch++) begin
                v = m_hist[ch][1];
                all_v = 1'b1;
                for (int unsigned i = 1; i <= DEB; i++)
                    if (m_hist[ch][i] != v) all_v = 1'b0;
                if (all_v && v != m_lvl[ch]) m_lvl[ch] = v;
                m_hist[ch] = {m_hist[ch][14:0], pin[ch]};
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge ACLK);
            model_step();
            check("position",  position,  m_pos);
            check("dir",       dir,       m_dir);
            check("key_level", key_level, m_key);
            check("flags",     flags,     m_flags);
            check("evt_pulse", evt_pulse, m_evt);
            if (evt_pulse) evt_seen++;
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic clear_flags();
        flag_clr = '1;
        run(1);
        flag_clr = '0;
        run(1);
    endtask

    task automatic lit(input string name, input longint dut_v, input longint mdl_v,
                       input longint exp);
        check({name, "_dut"}, dut_v, exp);
        check({name, "_mdl"}, mdl_v, exp);
    endtask

    initial begin
        model_reset();
        run(3);
        lit("rst_pos", position, m_pos, 0);
        lit("rst_flags", flags, m_flags, 0);
        lit("rst_key", key_level, m_key, 0);
        check("rst_dir", dir, 0);
        check("rst_evt", evt_pulse, 0);
        ARESET = 1'b0;
        run(5);

        // Three full CW cycles; first transition also pins the pin-to-count latency.
        evt_base = evt_seen;
        for (int k = 0; k < 12; k++) begin
            set_ab(cw_seq[k % 4]);
            if (k == 0) begin
                run(DEB + 2);
                lit("lat_before", position, m_pos, 0);
                run(1);
                lit("lat_at", position, m_pos, 1);
                run(3);
            end else begin
                run(10);
            end
        end
        lit("cw_pos", position, m_pos, 12);
        lit("cw_dir", dir, m_dir, 1);
        lit("cw_flags", flags, m_flags, 1);
        check("cw_evts", evt_seen - evt_base, 12);
        clear_flags();

        // Short glitch on A must be swallowed by the debouncer.
        evt_base = evt_seen;
        enc_a = 1'b1;
        run(3);
        enc_a = 1'b0;
        run(15);
        lit("glitch_pos", position, m_pos, 12);
        lit("glitch_flags", flags, m_flags, 0);
        check("glitch_evts", evt_seen - evt_base, 0);

        // Walk up to +127, wrap to -128, then clear coinciding with a CCW step.
        for (int k = 0; k < 115; k++) begin
            set_ab(cw_seq[k % 4]);
            run(6);
        end
        run(4);
        lit("max_pos", position, m_pos, 127);
        set_ab(2'b00);
        run(10);
        lit("wrap_pos", position, m_pos, -128);
        clear_flags();
        set_ab(2'b10);
        run(DEB + 2);
        pos_clr = 1'b1;
        run(1);
        pos_clr = 1'b0;
        run(5);
        lit("clr_pos", position, m_pos, 0);
        lit("clr_flags", flags, m_flags, 1);

        // Both phases changing together is an error, not a step.
        set_ab(2'b00);
        run(10);
        lit("pre_bad_pos", position, m_pos, 1);
        clear_flags();
        set_ab(2'b11);
        run(12);
        lit("bad_pos", position, m_pos, 1);
        lit("bad_flags", flags, m_flags, 8);
        flag_clr = 4'h8;
        run(1);
        flag_clr = '0;
        run(2);
        lit("bad_clr", flags, m_flags, 0);
        set_ab(2'b00);
        run(12);
        clear_flags();

        // Key held 30 cycles: press, then long press 20 cycles later, then release.
        key_n = 1'b0;
        run(15);
        lit("press_flags", flags, m_flags, 2);
        lit("press_key", key_level, m_key, 1);
        run(15);
        lit("long_flags", flags, m_flags, 6);
        key_n = 1'b1;
        run(15);
        lit("rel_flags", flags, m_flags, 6);
        lit("rel_key", key_level, m_key, 0);
        clear_flags();

        // Reset in the middle of a long press, then release.
        key_n = 1'b0;
        run(17);
        lit("mid_key", key_level, m_key, 1);
        ARESET = 1'b1;
        run(2);
        ARESET = 1'b0;
        key_n = 1'b1;
        evt_base = evt_seen;
        run(30);
        lit("abort_flags", flags, m_flags, 0);
        lit("abort_key", key_level, m_key, 0);
        lit("abort_pos", position, m_pos, 0);
        check("abort_evts", evt_seen - evt_base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
